// File: rtl/t08_mmio.sv
// t08_mmio: sequences instruction fetch and data access onto one req/ack bus and serves an internal MMIO window.
// Optional bus wait timeout is compiled in with `define T08_MMIO_BUS_TIMEOUT_EN.
module t08_mmio #(
    parameter logic [31:0] MMIO_BASE      = 32'hFFFF_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_pc,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_instr,
    output logic [31:0] cpu_rdata,
    output logic        cpu_freeze,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [31:0] gpio_out,
    output logic        bus_err
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {FETCH, EXEC, DATA, RETIRE} state_t;

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [31:0] cnt_q;

    logic        req;
    logic        ack_ok;
    logic        timeout;
    logic        in_win;
    logic [31:0] mmio_rd;

    // Reset masks the request combinationally so an ack arriving while reset is held cannot land.
    assign req    = ((state_q == FETCH) || (state_q == DATA)) && !reset;
    assign ack_ok = req && bus_ack;
    assign in_win = (cpu_addr[31:16] == MMIO_BASE[31:16]);

    always_comb begin
        mmio_rd = '0;
        case (cpu_addr[15:0])
            16'h0000: mmio_rd = gpio_q;
            16'h0004: mmio_rd = cnt_q;
            default:  mmio_rd = '0;
        endcase
    end

`ifdef T08_MMIO_BUS_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WAIT_W-1:0] wait_q;
    logic              err_q;

    assign timeout = req && !bus_ack && (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= (req && !bus_ack && !timeout) ? wait_q + WAIT_W'(1) : '0;
            if (timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus_err = err_q;
`else
    assign timeout = 1'b0;
    assign bus_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        rdata_d = rdata_q;
        gpio_d  = gpio_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            FETCH: begin
                if (ack_ok) begin
                    instr_d = bus_rdata;
                    state_d = EXEC;
                end else if (timeout) begin
                    instr_d = NOP;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!cpu_read && !cpu_write) begin
                    state_d = RETIRE;
                end else if (in_win) begin
                    if (cpu_write) begin
                        if (cpu_addr[15:0] == 16'h0000) begin
                            gpio_d = cpu_wdata;
                        end
                    end else begin
                        rdata_d = mmio_rd;
                    end
                    state_d = RETIRE;
                end else begin
                    addr_d  = cpu_addr & ~32'h3;
                    wdata_d = cpu_wdata;
                    we_d    = cpu_write;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (ack_ok) begin
                    if (!we_q) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = RETIRE;
                end else if (timeout) begin
                    if (!we_q) begin
                        rdata_d = 32'hDEAD_BEEF;
                    end
                    state_d = RETIRE;
                end
            end
            RETIRE:  state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            instr_q <= NOP;
            rdata_q <= '0;
            gpio_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            gpio_q  <= gpio_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_q + 32'd1;
        end
    end

    assign cpu_instr  = instr_q;
    assign cpu_rdata  = rdata_q;
    assign gpio_out   = gpio_q;
    assign cpu_freeze = (state_q != RETIRE);
    assign bus_req    = req;
    assign bus_we     = req && (state_q == DATA) && we_q;
    assign bus_addr   = !req ? '0 : ((state_q == FETCH) ? (cpu_pc & ~32'h3) : addr_q);
    assign bus_wdata  = (req && (state_q == DATA)) ? wdata_q : '0;

endmodule

// File: tb/tb_t08_mmio.sv
// Table-driven bench for t08_mmio: per-cycle vectors plus hand sequences for counter, reset and bus-wait cases.
module tb_t08_mmio;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I1  = 32'h1040_2083;
    localparam logic [31:0] S1  = 32'h0020_A023;
    localparam logic [31:0] CF  = 32'hCAFE_F00D;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] cpu_pc = '0, cpu_addr = '0, cpu_wdata = '0, bus_rdata = '0;
    logic        cpu_read = 1'b0, cpu_write = 1'b0, bus_ack = 1'b0;
    logic [31:0] cpu_instr, cpu_rdata, bus_addr, bus_wdata, gpio_out;
    logic        cpu_freeze, bus_req, bus_we, bus_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] tb_cnt;

    t08_mmio #(
        .MMIO_BASE      (32'hFFFF_0000),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_pc     (cpu_pc),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_instr  (cpu_instr),
        .cpu_rdata  (cpu_rdata),
        .cpu_freeze (cpu_freeze),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ack    (bus_ack),
        .gpio_out   (gpio_out),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: cleared by reset edges, +1 on every other edge.
    always @(posedge clk) tb_cnt <= reset ? 32'd0 : tb_cnt + 32'd1;

    typedef struct {
        logic        rst;
        logic [31:0] pc, addr, wdata;
        logic        rd, wr, ack;
        logic [31:0] brd;
        logic        frz, req, we;
        logic [31:0] baddr, bwd, instr, rdata, gpio;
    } vec_t;

    localparam int NV = 28;
    vec_t tv [NV];

    function automatic vec_t v(input logic rst, input logic [31:0] pc, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic rd, input logic wr, input logic ack,
                               input logic [31:0] brd, input logic frz, input logic req, input logic we,
                               input logic [31:0] baddr, input logic [31:0] bwd, input logic [31:0] instr,
                               input logic [31:0] rdata, input logic [31:0] gpio);
        vec_t r;
        r.rst = rst; r.pc = pc; r.addr = addr; r.wdata = wdata;
        r.rd = rd; r.wr = wr; r.ack = ack; r.brd = brd;
        r.frz = frz; r.req = req; r.we = we; r.baddr = baddr; r.bwd = bwd;
        r.instr = instr; r.rdata = rdata; r.gpio = gpio;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [31:0] pc, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic rd, input logic wr, input logic ack,
                         input logic [31:0] brd);
        @(posedge clk);
        #1;
        reset = rst; cpu_pc = pc; cpu_addr = addr; cpu_wdata = wdata;
        cpu_read = rd; cpu_write = wr; bus_ack = ack; bus_rdata = brd;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_cnt;
        int          n;
        bit          done;

        //            rst pc      addr          wdata         rd wr ack brd             frz req we baddr        bwd           instr rdata gpio
        tv[0]  = v(1, 32'h0,  32'h0,        32'h0,        0, 0, 0, 32'h0,         1, 0, 0, 32'h0,       32'h0,        NOP, 32'h0, 32'h0);
        tv[1]  = v(0, 32'h0,  32'h0,        32'h0,        0, 0, 1, 32'h93,        1, 1, 0, 32'h0,       32'h0,        NOP, 32'h0, 32'h0);
        tv[2]  = v(0, 32'h0,  32'h0,        32'h0,        0, 0, 0, 32'h0,         1, 0, 0, 32'h0,       32'h0,        32'h93, 32'h0, 32'h0);
        tv[3]  = v(0, 32'h0,  32'h0,        32'h0,        0, 0, 0, 32'h0,         0, 0, 0, 32'h0,       32'h0,        32'h93, 32'h0, 32'h0);
        tv[4]  = v(0, 32'h4,  32'h0,        32'h0,        0, 0, 1, I1,            1, 1, 0, 32'h4,       32'h0,        32'h93, 32'h0, 32'h0);
        tv[5]  = v(0, 32'h4,  32'h104,      32'h0,        1, 0, 0, 32'h0,         1, 0, 0, 32'h0,       32'h0,        I1, 32'h0, 32'h0);
        tv[6]  = v(0, 32'h4,  32'h104,      32'h0,        1, 0, 0, 32'h0,         1, 1, 0, 32'h104,     32'h0,        I1, 32'h0, 32'h0);
        tv[7]  = v(0, 32'h4,  32'hFFFF0000, 32'hAAAA5555, 1, 0, 0, 32'h0,         1, 1, 0, 32'h104,     32'h0,        I1, 32'h0, 32'h0);
        tv[8]  = v(0, 32'h4,  32'h104,      32'h0,        1, 0, 1, CF,            1, 1, 0, 32'h104,     32'h0,        I1, 32'h0, 32'h0);
        tv[9]  = v(0, 32'h4,  32'h104,      32'h0,        1, 0, 1, 32'h11111111,  0, 0, 0, 32'h0,       32'h0,        I1, CF, 32'h0);
        tv[10] = v(0, 32'h8,  32'h0,        32'h0,        0, 0, 0, 32'h22222222,  1, 1, 0, 32'h8,       32'h0,        I1, CF, 32'h0);
        tv[11] = v(0, 32'h8,  32'h0,        32'h0,        0, 0, 1, S1,            1, 1, 0, 32'h8,       32'h0,        I1, CF, 32'h0);
        tv[12] = v(0, 32'h8,  32'h203,      32'h12345678, 1, 1, 1, 32'h33333333,  1, 0, 0, 32'h0,       32'h0,        S1, CF, 32'h0);
        tv[13] = v(0, 32'h8,  32'h203,      32'h12345678, 1, 1, 1, 32'hBBBBBBBB,  1, 1, 1, 32'h200,     32'h12345678, S1, CF, 32'h0);
        tv[14] = v(0, 32'h8,  32'h0,        32'h0,        0, 0, 0, 32'h0,         0, 0, 0, 32'h0,       32'h0,        S1, CF, 32'h0);
        tv[15] = v(0, 32'hC,  32'h0,        32'h0,        0, 0, 1, NOP,           1, 1, 0, 32'hC,       32'h0,        S1, CF, 32'h0);
        tv[16] = v(0, 32'hC,  32'hFFFF0000, 32'h5A,       0, 1, 0, 32'h0,         1, 0, 0, 32'h0,       32'h0,        NOP, CF, 32'h0);
        tv[17] = v(0, 32'hC,  32'h0,        32'h0,        0, 0, 0, 32'h0,         0, 0, 0, 32'h0,       32'h0,        NOP, CF, 32'h5A);
        tv[18] = v(0, 32'h10, 32'h0,        32'h0,        0, 0, 1, NOP,           1, 1, 0, 32'h10,      32'h0,        NOP, CF, 32'h5A);
        tv[19] = v(0, 32'h10, 32'hFFFF0008, 32'hFFFFFFFF, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0,       32'h0,        NOP, CF, 32'h5A);
        tv[20] = v(0, 32'h10, 32'h0,        32'h0,        0, 0, 0, 32'h0,         0, 0, 0, 32'h0,       32'h0,        NOP, CF, 32'h5A);
        tv[21] = v(0, 32'h14, 32'h0,        32'h0,        0, 0, 1, NOP,           1, 1, 0, 32'h14,      32'h0,        NOP, CF, 32'h5A);
        tv[22] = v(0, 32'h14, 32'hFFFF0000, 32'h0,        1, 0, 0, 32'h0,         1, 0, 0, 32'h0,       32'h0,        NOP, CF, 32'h5A);
        tv[23] = v(0, 32'h14, 32'h0,        32'h0,        0, 0, 0, 32'h0,         0, 0, 0, 32'h0,       32'h0,        NOP, 32'h5A, 32'h5A);
        tv[24] = v(0, 32'h18, 32'h0,        32'h0,        0, 0, 1, NOP,           1, 1, 0, 32'h18,      32'h0,        NOP, 32'h5A, 32'h5A);
        tv[25] = v(0, 32'h18, 32'hFFFF0008, 32'h0,        1, 0, 0, 32'h0,         1, 0, 0, 32'h0,       32'h0,        NOP, 32'h5A, 32'h5A);
        tv[26] = v(0, 32'h18, 32'h0,        32'h0,        0, 0, 0, 32'h0,         0, 0, 0, 32'h0,       32'h0,        NOP, 32'h0, 32'h5A);
        tv[27] = v(0, 32'h1C, 32'h0,        32'h0,        0, 0, 0, 32'h0,         1, 1, 0, 32'h1C,      32'h0,        NOP, 32'h0, 32'h5A);

        for (int i = 0; i < NV; i++) begin
            drive(tv[i].rst, tv[i].pc, tv[i].addr, tv[i].wdata, tv[i].rd, tv[i].wr, tv[i].ack, tv[i].brd);
            chk($sformatf("r%0d.freeze", i), 32'(cpu_freeze), 32'(tv[i].frz));
            chk($sformatf("r%0d.req", i), 32'(bus_req), 32'(tv[i].req));
            chk($sformatf("r%0d.instr", i), cpu_instr, tv[i].instr);
            chk($sformatf("r%0d.rdata", i), cpu_rdata, tv[i].rdata);
            chk($sformatf("r%0d.gpio", i), gpio_out, tv[i].gpio);
            chk($sformatf("r%0d.err", i), 32'(bus_err), 32'h0);
            if (tv[i].req || tv[i].rst) begin
                chk($sformatf("r%0d.we", i), 32'(bus_we), 32'(tv[i].we));
                chk($sformatf("r%0d.addr", i), bus_addr, tv[i].baddr);
            end
            if (tv[i].we || tv[i].rst) begin
                chk($sformatf("r%0d.wdata", i), bus_wdata, tv[i].bwd);
            end
        end

        // Cycle counter read through the window
        drive(0, 32'h1C, 32'h0, 32'h0, 0, 0, 1, NOP);
        chk("cnt.fetch_req", 32'(bus_req), 32'h1);
        drive(0, 32'h1C, 32'hFFFF0004, 32'h0, 1, 0, 0, 32'h0);
        exp_cnt = tb_cnt;
        chk("cnt.exec_noreq", 32'(bus_req), 32'h0);
        drive(0, 32'h1C, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        chk("cnt.retire_freeze", 32'(cpu_freeze), 32'h0);
        chk("cnt.rdata", cpu_rdata, exp_cnt);

        // Reset during a DATA wait; just outside the window so it must use the bus
        drive(0, 32'h20, 32'h0, 32'h0, 0, 0, 1, NOP);
        drive(0, 32'h20, 32'hFFFE0004, 32'h0, 1, 0, 0, 32'h0);
        chk("rst.exec_noreq", 32'(bus_req), 32'h0);
        drive(0, 32'h20, 32'hFFFE0004, 32'h0, 1, 0, 0, 32'h0);
        chk("rst.data_req", 32'(bus_req), 32'h1);
        chk("rst.data_addr", bus_addr, 32'hFFFE0004);
        drive(1, 32'h20, 32'hFFFE0004, 32'h0, 1, 0, 0, 32'h0);
        drive(1, 32'h20, 32'hFFFE0004, 32'h0, 1, 0, 1, 32'h77777777);
        chk("rst.req_dropped", 32'(bus_req), 32'h0);
        chk("rst.freeze", 32'(cpu_freeze), 32'h1);
        chk("rst.instr", cpu_instr, NOP);
        chk("rst.rdata", cpu_rdata, 32'h0);
        chk("rst.gpio", gpio_out, 32'h0);
        drive(0, 32'h40, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        chk("rst.new_fetch_req", 32'(bus_req), 32'h1);
        chk("rst.new_fetch_addr", bus_addr, 32'h40);
        chk("rst.instr_after", cpu_instr, NOP);
        chk("rst.rdata_after", cpu_rdata, 32'h0);

        // Long DATA read wait with no ack
        drive(0, 32'h40, 32'h0, 32'h0, 0, 0, 1, NOP);
        drive(0, 32'h40, 32'h400, 32'h0, 1, 0, 0, 32'h0);
        chk("wait.exec_noreq", 32'(bus_req), 32'h0);
`ifdef T08_MMIO_BUS_TIMEOUT_EN
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            drive(0, 32'h40, 32'h400, 32'h0, 1, 0, 0, 32'h0);
            if (bus_req) n++;
            else done = 1'b1;
        end
        chk("to.req_cycles", 32'(n), 32'd16);
        chk("to.retire_freeze", 32'(cpu_freeze), 32'h0);
        chk("to.err", 32'(bus_err), 32'h1);
        chk("to.rdata", cpu_rdata, 32'hDEADBEEF);
        drive(0, 32'h44, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        chk("to.err_sticky", 32'(bus_err), 32'h1);
        chk("to.next_fetch", 32'(bus_req), 32'h1);
`else
        n = 0;
        for (int k = 0; k < 20; k++) begin
            drive(0, 32'h40, 32'h400, 32'h0, 1, 0, 0, 32'h0);
            if (bus_req && bus_addr == 32'h400 && !bus_we) n++;
        end
        chk("wait.held_cycles", 32'(n), 32'd20);
        chk("wait.err", 32'(bus_err), 32'h0);
        drive(0, 32'h40, 32'h400, 32'h0, 1, 0, 1, 32'h0F0F0F0F);
        chk("wait.still_frozen", 32'(cpu_freeze), 32'h1);
        drive(0, 32'h40, 32'h0, 32'h0, 0, 0, 0, 32'h0);
        chk("wait.retire_freeze", 32'(cpu_freeze), 32'h0);
        chk("wait.rdata", cpu_rdata, 32'h0F0F0F0F);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
